// File: rtl/ram_burst_master.sv
// Burst command front-end for the 1024x8 single-port synchronous RAM.
// Sequences the RAM pins one beat per cycle and realigns registered read data onto a stream port.
module ram_burst_master #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              busy,
    output logic              ram_cs,
    output logic              ram_rd,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [ADDR_W-1:0]  cur_addr;
    logic [LEN_W-1:0]   beats_left;
    logic               dir;
    logic               cmd_fire;
    logic               wr_fire;
    logic               rd_issue;
    logic               last_beat;
    logic               p1_valid;
    logic               p1_last;
    logic               p2_valid;
    logic               p2_last;

    assign last_beat = (beats_left == LEN_W'(0));
    assign cmd_fire  = cmd_valid && cmd_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (cmd_fire) begin
                    state_nx = cmd_wr ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                if (wr_fire && last_beat) begin
                    state_nx = S_IDLE;
                end
            end
            S_READ: begin
                if (rd_issue && last_beat) begin
                    state_nx = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Leave once the final read beat has been presented
                if (rd_valid && rd_last) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Handshake and issue decode
    always_comb begin
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        busy      = 1'b0;
        wr_fire   = 1'b0;
        rd_issue  = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = !rst;
            end
            S_WRITE: begin
                wr_ready = !rst;
                busy     = 1'b1;
                wr_fire  = wr_valid && dir && !rst;
            end
            S_READ: begin
                busy     = 1'b1;
                rd_issue = !dir && !rst;
            end
            S_DRAIN: begin
                busy = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Command context and RAM pin registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_addr   <= '0;
            beats_left <= '0;
            dir        <= 1'b0;
            ram_cs     <= 1'b0;
            ram_rd     <= 1'b0;
            ram_wr     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
        end else begin
            ram_cs <= wr_fire || rd_issue;
            ram_rd <= rd_issue;
            ram_wr <= wr_fire;
            if (wr_fire) begin
                ram_addr  <= cur_addr;
                ram_wdata <= wr_data;
            end else if (rd_issue) begin
                ram_addr <= cur_addr;
            end
            if (cmd_fire) begin
                cur_addr   <= cmd_addr;
                beats_left <= cmd_len;
                dir        <= cmd_wr;
            end else if (wr_fire || rd_issue) begin
                cur_addr   <= cur_addr + ADDR_W'(1);
                beats_left <= beats_left - LEN_W'(1);
            end
        end
    end

    // Read return: issue -> RAM output -> stream register
    always_ff @(posedge clk) begin
        if (rst) begin
            p1_valid <= 1'b0;
            p1_last  <= 1'b0;
            p2_valid <= 1'b0;
            p2_last  <= 1'b0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            rd_data  <= '0;
        end else begin
            p1_valid <= rd_issue;
            p1_last  <= rd_issue && last_beat;
            p2_valid <= p1_valid;
            p2_last  <= p1_last;
            rd_valid <= p2_valid;
            rd_last  <= p2_last;
            if (p2_valid) begin
                rd_data <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_ram_burst_master.sv
// Directed bench for ram_burst_master with a registered-read 1024x8 RAM model.
module tb_ram_burst_master;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_wr;
    logic [9:0] cmd_addr;
    logic [3:0] cmd_len;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_data;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_last;
    logic       busy;
    logic       ram_cs;
    logic       ram_rd;
    logic       ram_wr;
    logic [9:0] ram_addr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;

    logic [7:0] mem [1024];
    logic [7:0] wdat [16];
    logic [7:0] rexp [16];
    int         n_chk;
    int         n_pass;
    int         n_wr_pulses;

    ram_burst_master dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_wr    (cmd_wr),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .busy      (busy),
        .ram_cs    (ram_cs),
        .ram_rd    (ram_rd),
        .ram_wr    (ram_wr),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: write and registered read on the rising edge
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 7 + 3);
        ram_rdata = 8'h00;
    end
    always @(posedge clk) begin
        if (ram_cs && ram_wr) mem[ram_addr] <= ram_wdata;
        if (ram_cs && ram_rd) ram_rdata <= mem[ram_addr];
    end

    function automatic logic [7:0] init_val(input logic [9:0] a);
        return 8'(32'(a) * 7 + 3);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Pin-level invariants and write pulse count, every cycle outside reset
    always @(negedge clk) begin
        if (!rst) begin
            chk("rd_and_wr", 32'(ram_rd & ram_wr), 32'd0);
            chk("cs_eq_or", 32'(ram_cs), 32'(ram_rd | ram_wr));
            chk("wr_ready_idle", 32'(wr_ready & ~busy), 32'd0);
            if (ram_wr) n_wr_pulses++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Write burst with wr_valid held high; called at a negedge in IDLE
    task automatic write_burst(input logic [9:0] a, input logic [3:0] len);
        logic [9:0] ea;
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = a; cmd_len = len;
        tick();
        cmd_valid = 1'b0;
        chk("wr_busy", 32'(busy), 32'd1);
        for (int i = 0; i <= int'(len); i++) begin
            wr_valid = 1'b1; wr_data = wdat[i];
            tick();
            ea = a + 10'(i);
            chk("wr_pulse", 32'(ram_wr), 32'd1);
            chk("wr_addr", 32'(ram_addr), 32'(ea));
            chk("wr_data", 32'(ram_wdata), 32'(wdat[i]));
            chk("wr_cmd_ready", 32'(cmd_ready), (i == int'(len)) ? 32'd1 : 32'd0);
        end
        wr_valid = 1'b0;
        tick();
        chk("wr_cs_after", 32'(ram_cs), 32'd0);
    endtask

    // Checks a read burst cycle by cycle; called at the negedge right after accept
    task automatic read_check(input logic [9:0] a, input logic [3:0] len);
        int         beats;
        int         l;
        logic [9:0] ea;
        beats = 0;
        l = int'(len);
        for (int k = 1; k <= l + 4; k++) begin
            tick();
            if (k <= l + 1) begin
                ea = a + 10'(k - 1);
                chk("rd_issue", 32'(ram_rd), 32'd1);
                chk("rd_addr", 32'(ram_addr), 32'(ea));
            end
            chk("rd_wr_ready", 32'(wr_ready), 32'd0);
            chk("rd_valid", 32'(rd_valid), (k >= 3 && k <= l + 3) ? 32'd1 : 32'd0);
            chk("rd_last", 32'(rd_last), (k == l + 3) ? 32'd1 : 32'd0);
            if (rd_valid) begin
                if (beats < 16) chk("rd_data", 32'(rd_data), 32'(rexp[beats]));
                beats++;
            end
            chk("rd_cmd_ready", 32'(cmd_ready), (k == l + 4) ? 32'd1 : 32'd0);
        end
        chk("rd_beats", 32'(beats), 32'(l + 1));
        chk("rd_busy_end", 32'(busy), 32'd0);
    endtask

    task automatic read_burst(input logic [9:0] a, input logic [3:0] len);
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = a; cmd_len = len;
        tick();
        cmd_valid = 1'b0;
        read_check(a, len);
    endtask

    initial begin
        n_chk = 0; n_pass = 0; n_wr_pulses = 0;
        rst = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = '0;
        tick();
        tick();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_cs", 32'(ram_cs), 32'd0);
        chk("post_rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("post_rst_addr", 32'(ram_addr), 32'd0);

        // Single write then read
        n_wr_pulses = 0;
        wdat[0] = 8'hA5;
        write_burst(10'h005, 4'd0);
        chk("single_wr_pulses", 32'(n_wr_pulses), 32'd1);
        rexp[0] = 8'hA5;
        read_burst(10'h005, 4'd0);

        // Burst crossing the top of the address space
        wdat[0] = 8'h11; wdat[1] = 8'h22; wdat[2] = 8'h33; wdat[3] = 8'h44;
        write_burst(10'h3FE, 4'd3);
        rexp[0] = 8'h11; rexp[1] = 8'h22; rexp[2] = 8'h33; rexp[3] = 8'h44;
        read_burst(10'h3FE, 4'd3);

        // Write burst with two idle cycles between beats
        n_wr_pulses = 0;
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 10'h050; cmd_len = 4'd2;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1; wr_data = 8'(8'h61 + i);
            tick();
            wr_valid = 1'b0;
            chk("stall_pulse", 32'(ram_wr), 32'd1);
            chk("stall_addr", 32'(ram_addr), 32'(10'h050 + 10'(i)));
            chk("stall_data", 32'(ram_wdata), 32'(8'h61 + i));
            chk("stall_cmd_ready", 32'(cmd_ready), (i == 2) ? 32'd1 : 32'd0);
            if (i < 2) begin
                for (int g = 0; g < 2; g++) begin
                    tick();
                    chk("stall_gap_cs", 32'(ram_cs), 32'd0);
                    chk("stall_gap_cmd_ready", 32'(cmd_ready), 32'd0);
                    chk("stall_gap_wr_ready", 32'(wr_ready), 32'd1);
                end
            end
        end
        tick();
        chk("stall_wr_pulses", 32'(n_wr_pulses), 32'd3);
        rexp[0] = 8'h61; rexp[1] = 8'h62; rexp[2] = 8'h63;
        read_burst(10'h050, 4'd2);

        // cmd_valid held through a 16-beat read; next command taken on first IDLE cycle
        for (int i = 0; i < 16; i++) rexp[i] = init_val(10'h100 + 10'(i));
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 10'h100; cmd_len = 4'd15;
        tick();
        cmd_addr = 10'h200; cmd_len = 4'd0;
        read_check(10'h100, 4'd15);
        tick();
        cmd_valid = 1'b0;
        chk("block_second_busy", 32'(busy), 32'd1);
        rexp[0] = init_val(10'h200);
        read_check(10'h200, 4'd0);

        // Reset with two reads in flight
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 10'h300; cmd_len = 4'd3;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        chk("mid_rd_issue", 32'(ram_rd), 32'd1);
        rst = 1'b1;
        tick();
        chk("rst_mid_cs", 32'(ram_cs), 32'd0);
        chk("rst_mid_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_cmd_ready", 32'(cmd_ready), 32'd0);
        rst = 1'b0;
        tick();
        chk("rst_mid_cmd_ready_after", 32'(cmd_ready), 32'd1);
        for (int k = 0; k < 5; k++) begin
            chk("rst_no_stale", 32'(rd_valid), 32'd0);
            chk("rst_no_issue", 32'(ram_cs), 32'd0);
            tick();
        end

        // Controller still fully usable after the abort
        rexp[0] = init_val(10'h301);
        read_burst(10'h301, 4'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
